// File: rtl/piso_src_arb_if.sv
// Producer-FIFO / piso / decoder-side signal bundle for piso_src_arb.
// master is the arbiter side, slave is the FIFO/piso/decoder side.
interface piso_src_arb_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_empty_i;
    logic              req0_rd_en_o;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_empty_i;
    logic              req1_rd_en_o;
    logic [DATA_W-1:0] piso_data_o;
    logic              piso_empty_o;
    logic              piso_rd_en_i;
    logic [1:0]        grant_o;
    logic              frame_start_o;
    logic              frame_done_o;
    logic              busy_o;

    modport master (
        input  req0_data_i, req0_empty_i,
        input  req1_data_i, req1_empty_i,
        input  piso_rd_en_i,
        output req0_rd_en_o, req1_rd_en_o,
        output piso_data_o, piso_empty_o,
        output grant_o, frame_start_o,
        output frame_done_o, busy_o
    );

    modport slave (
        output req0_data_i, req0_empty_i,
        output req1_data_i, req1_empty_i,
        output piso_rd_en_i,
        input  req0_rd_en_o, req1_rd_en_o,
        input  piso_data_o, piso_empty_o,
        input  grant_o, frame_start_o,
        input  frame_done_o, busy_o
    );
endinterface

// File: rtl/piso_src_arb.sv
// Frame-level round-robin arbiter sharing one piso between two FIFOs.
// Holds each grant for a whole frame, then drains the piso before rearbitrating.
module piso_src_arb #(
    parameter int DATA_W       = 16,
    parameter int FRAME_WORDS  = 4,
    parameter int DRAIN_CYCLES = 9
) (
    input  logic            clk,
    input  logic            rst,
    piso_src_arb_if.master  bus
);
    localparam int CW = $clog2(FRAME_WORDS) + 1;
    localparam int DW = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              rr_ptr;
    logic [1:0]        grant_q;
    logic [CW-1:0]     word_cnt;
    logic [DW-1:0]     drain_cnt;
    logic              done_q;
    logic              busy_q;

    logic              owner;
    logic              req_any;
    logic              pick;
    logic              rd0;
    logic              rd1;
    logic              pop;
    logic              last_pop;
    logic              drain_end;
    logic              done_nx;
    logic [DATA_W-1:0] pdata;
    logic              pempty;
    logic              fstart;

    assign owner   = grant_q[1];
    assign req_any = ~bus.req0_empty_i | ~bus.req1_empty_i;
    // both pending: rr_ptr decides; otherwise the lone non-empty one wins
    assign pick    = (req_any && !bus.req0_empty_i && !bus.req1_empty_i)
                   ? rr_ptr : bus.req0_empty_i;

    assign pop       = rd0 | rd1;
    assign last_pop  = pop && (word_cnt == CW'(FRAME_WORDS - 1));
    assign drain_end = (state == DRAIN) && (drain_cnt == '0);
    // registered pulse must land in the cycle where drain_cnt reaches 0
    assign done_nx   = ((state == DRAIN) && (drain_cnt == DW'(1)))
                     || (last_pop && (DRAIN_CYCLES == 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = GRANT;
            GRANT:   if (last_pop) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pdata  = '0;
        pempty = 1'b1;
        rd0    = 1'b0;
        rd1    = 1'b0;
        fstart = 1'b0;
        if (state == GRANT) begin
            if (!owner) begin
                pdata  = bus.req0_data_i;
                pempty = bus.req0_empty_i;
                rd0    = bus.piso_rd_en_i & ~bus.req0_empty_i;
            end else begin
                pdata  = bus.req1_data_i;
                pempty = bus.req1_empty_i;
                rd1    = bus.piso_rd_en_i & ~bus.req1_empty_i;
            end
            fstart = (rd0 | rd1) && (word_cnt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            grant_q   <= 2'b00;
            word_cnt  <= '0;
            drain_cnt <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= done_nx;
            if (state == IDLE && req_any) begin
                grant_q <= pick ? 2'b10 : 2'b01;
            end else if (drain_end) begin
                grant_q <= 2'b00;
                rr_ptr  <= ~owner;
            end
            if (pop) begin
                word_cnt <= last_pop ? '0 : word_cnt + CW'(1);
            end
            if (last_pop) begin
                drain_cnt <= DW'(DRAIN_CYCLES - 1);
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
        end
    end

    assign bus.req0_rd_en_o  = rd0;
    assign bus.req1_rd_en_o  = rd1;
    assign bus.piso_data_o   = pdata;
    assign bus.piso_empty_o  = pempty;
    assign bus.grant_o       = grant_q;
    assign bus.frame_start_o = fstart;
    assign bus.frame_done_o  = done_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_piso_src_arb.sv
// Directed bench for piso_src_arb with FIFO and piso shift models.
// Pops and piso loads follow the rd_en strobes sampled mid-cycle.
module tb_piso_src_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_src_arb_if #(.DATA_W(16)) bus();

    piso_src_arb #(
        .DATA_W(16),
        .FRAME_WORDS(4),
        .DRAIN_CYCLES(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [1:0]  syms[$];
    logic [1:0]  exp_syms[$];
    bit          pop_src[$];
    int          fs_at[$];

    int cyc = 0;
    int n_pop0 = 0, n_pop1 = 0, n_fs = 0, n_fd = 0, npop = 0;
    int last_pop_cyc = 0, fd_cyc = 0;
    int b0, b1, bfs, bfd, bnp, sb, bfa;

    logic        force_rd = 1'b0;
    logic [15:0] sr = '0;
    int          pcnt = 0;
    logic        s_rd0 = 1'b0, s_rd1 = 1'b0;
    logic [15:0] s_pdata = '0;

    // piso takes a word only when idle and the arbiter offers one
    assign bus.piso_rd_en_i = force_rd
        | ((pcnt == 0) && !bus.piso_empty_o);

    always @(negedge clk) begin
        s_rd0   = bus.req0_rd_en_o;
        s_rd1   = bus.req1_rd_en_o;
        s_pdata = bus.piso_data_o;
        if (s_rd0 | s_rd1) begin
            if (bus.frame_start_o) fs_at.push_back(npop);
            pop_src.push_back(s_rd1);
            npop++;
            if (s_rd0) n_pop0++;
            else n_pop1++;
            last_pop_cyc = cyc;
        end
        if (bus.frame_start_o) n_fs++;
        if (bus.frame_done_o) begin
            n_fd++;
            fd_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            pcnt = 0;
        end else begin
            if (s_rd0 && q0.size() != 0) q0.delete(0);
            if (s_rd1 && q1.size() != 0) q1.delete(0);
            if (s_rd0 | s_rd1) begin
                sr   = s_pdata;
                pcnt = 8;
            end else if (pcnt != 0) begin
                syms.push_back(sr[15:14]);
                sr = sr << 2;
                pcnt--;
            end
        end
        bus.req0_empty_i = (q0.size() == 0);
        bus.req0_data_i  = (q0.size() != 0) ? q0[0] : 16'h0;
        bus.req1_empty_i = (q1.size() == 0);
        bus.req1_data_i  = (q1.size() != 0) ? q1[0] : 16'h0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic rst_on();
        rst = 1'b1;
        force_rd = 1'b0;
        q0.delete();
        q1.delete();
        step();
    endtask

    task automatic rst_off();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic mark();
        b0  = n_pop0;
        b1  = n_pop1;
        bfs = n_fs;
        bfd = n_fd;
        bnp = npop;
        sb  = syms.size();
        bfa = fs_at.size();
        exp_syms.delete();
    endtask

    function automatic void add_word(logic [15:0] w);
        for (int k = 7; k >= 0; k--) exp_syms.push_back(w[2*k+1 -: 2]);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (bus.grant_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_grant got=%b want=00", bus.grant_o);
        end
        total++;
        if (bus.piso_empty_o !== 1'b1 || bus.piso_data_o !== 16'h0) begin
            bad++;
            $display("FAIL reset_piso got=%b/%h want=1/0000",
                     bus.piso_empty_o, bus.piso_data_o);
        end
        total++;
        if ({bus.req0_rd_en_o, bus.req1_rd_en_o, bus.frame_start_o,
             bus.frame_done_o, bus.busy_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b%b%b%b%b want=00000",
                     bus.req0_rd_en_o, bus.req1_rd_en_o, bus.frame_start_o,
                     bus.frame_done_o, bus.busy_o);
        end
    endtask

    task automatic test_single();
        logic [15:0] w[4];
        int k;
        int m;
        w[0] = 16'hAAAA; w[1] = 16'h5555; w[2] = 16'hFFFF; w[3] = 16'h0000;
        rst_on();
        for (int i = 0; i < 4; i++) q0.push_back(w[i]);
        rst_off();
        mark();
        for (int i = 0; i < 4; i++) add_word(w[i]);
        k = 0;
        while (n_pop0 == b0 && k < 50) begin step(); k++; end
        total++;
        if (k >= 50 || bus.grant_o !== 2'b01 || bus.frame_start_o !== 1'b1
            || bus.piso_data_o !== 16'hAAAA) begin
            bad++;
            $display("FAIL single_first grant=%b fs=%b data=%h want 01/1/aaaa",
                     bus.grant_o, bus.frame_start_o, bus.piso_data_o);
        end
        k = 0;
        while (n_fd == bfd && k < 200) begin step(); k++; end
        total++;
        if (k >= 200 || n_pop0 - b0 != 4 || n_pop1 - b1 != 0) begin
            bad++;
            $display("FAIL single_pops got=%0d/%0d want=4/0",
                     n_pop0 - b0, n_pop1 - b1);
        end
        total++;
        if (fd_cyc - last_pop_cyc != 9 || n_fs - bfs != 1) begin
            bad++;
            $display("FAIL single_done_gap got=%0d fs=%0d want=9/1",
                     fd_cyc - last_pop_cyc, n_fs - bfs);
        end
        m = 0;
        if (syms.size() - sb != exp_syms.size()) m = -1;
        else for (int i = 0; i < exp_syms.size(); i++)
            if (syms[sb+i] !== exp_syms[i]) m++;
        total++;
        if (m != 0) begin
            bad++;
            $display("FAIL single_syms got_n=%0d want_n=%0d mism=%0d",
                     syms.size() - sb, exp_syms.size(), m);
        end
    endtask

    task automatic test_contention();
        int k;
        int m;
        rst_on();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(16'h0100 + 16'(i));
            q1.push_back(16'h0200 + 16'(i));
        end
        rst_off();
        mark();
        k = 0;
        while (n_fd < bfd + 4 && k < 800) begin step(); k++; end
        m = 0;
        if (npop - bnp != 16) m = -1;
        else for (int i = 0; i < 16; i++)
            if (pop_src[bnp+i] != bit'((i / 4) % 2)) m++;
        total++;
        if (k >= 800 || m != 0) begin
            bad++;
            $display("FAIL contention_order pops=%0d mism=%0d want=16/0",
                     npop - bnp, m);
        end
        m = 0;
        if (fs_at.size() - bfa != 4) m = -1;
        else for (int i = 0; i < 4; i++)
            if (fs_at[bfa+i] != bnp + 4 * i) m++;
        total++;
        if (m != 0 || n_fs - bfs != 4 || n_fd - bfd != 4) begin
            bad++;
            $display("FAIL contention_frames fs=%0d fd=%0d mism=%0d want=4/4/0",
                     n_fs - bfs, n_fd - bfd, m);
        end
    endtask

    task automatic test_underflow();
        int k;
        rst_on();
        q0.push_back(16'h1111);
        q0.push_back(16'h2222);
        for (int i = 0; i < 8; i++) q1.push_back(16'h3000 + 16'(i));
        rst_off();
        mark();
        k = 0;
        while (n_pop0 < b0 + 2 && k < 100) begin step(); k++; end
        repeat (20) step();
        total++;
        if (k >= 100 || bus.grant_o !== 2'b01 || bus.piso_empty_o !== 1'b1
            || bus.busy_o !== 1'b1 || n_pop1 != b1 || n_fd != bfd) begin
            bad++;
            $display("FAIL underflow_stall grant=%b empty=%b pop1=%0d fd=%0d",
                     bus.grant_o, bus.piso_empty_o, n_pop1 - b1, n_fd - bfd);
        end
        q0.push_back(16'h4444);
        q0.push_back(16'h5555);
        k = 0;
        while (n_pop1 == b1 && k < 200) begin step(); k++; end
        total++;
        if (k >= 200 || bus.grant_o !== 2'b10 || n_pop0 - b0 != 4
            || n_fd - bfd != 1) begin
            bad++;
            $display("FAIL underflow_resume grant=%b pop0=%0d fd=%0d want 10/4/1",
                     bus.grant_o, n_pop0 - b0, n_fd - bfd);
        end
    endtask

    task automatic test_drain_guard();
        int k;
        rst_on();
        for (int i = 0; i < 4; i++) q0.push_back(16'h7000 + 16'(i));
        rst_off();
        mark();
        k = 0;
        while (n_pop0 < b0 + 4 && k < 100) begin step(); k++; end
        total++;
        if (k >= 100) begin
            bad++;
            $display("FAIL drain_setup got=%0d want=4", n_pop0 - b0);
        end
        for (int i = 0; i < 4; i++) q1.push_back(16'h8000 + 16'(i));
        q0.push_back(16'h9000);
        q0.push_back(16'h9001);
        force_rd = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            total++;
            if ({bus.req0_rd_en_o, bus.req1_rd_en_o, bus.piso_empty_o,
                 bus.grant_o} !== 5'b00101) begin
                bad++;
                $display("FAIL drain_cyc%0d rd=%b%b empty=%b grant=%b",
                         i, bus.req0_rd_en_o, bus.req1_rd_en_o,
                         bus.piso_empty_o, bus.grant_o);
            end
        end
        total++;
        if (bus.frame_done_o !== 1'b1 || n_fd - bfd != 1) begin
            bad++;
            $display("FAIL drain_done got=%b/%0d want=1/1",
                     bus.frame_done_o, n_fd - bfd);
        end
        step();
        total++;
        if (bus.grant_o !== 2'b00 || n_pop0 - b0 != 4 || n_pop1 - b1 != 0) begin
            bad++;
            $display("FAIL drain_idle grant=%b pops=%0d/%0d want 00/4/0",
                     bus.grant_o, n_pop0 - b0, n_pop1 - b1);
        end
        step();
        total++;
        if (bus.grant_o !== 2'b10 || bus.req1_rd_en_o !== 1'b1) begin
            bad++;
            $display("FAIL drain_next grant=%b rd1=%b want 10/1",
                     bus.grant_o, bus.req1_rd_en_o);
        end
        force_rd = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        rst_on();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(16'hA000 + 16'(i));
            q1.push_back(16'hB000 + 16'(i));
        end
        rst_off();
        mark();
        k = 0;
        while (n_pop0 == b0 && k < 50) begin step(); k++; end
        step();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (k >= 50 || bus.grant_o !== 2'b00 || bus.busy_o !== 1'b0
            || bus.piso_empty_o !== 1'b1 || bus.frame_done_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async grant=%b busy=%b empty=%b fd=%b",
                     bus.grant_o, bus.busy_o, bus.piso_empty_o,
                     bus.frame_done_o);
        end
        step();
        step();
        total++;
        if (n_fd != bfd) begin
            bad++;
            $display("FAIL rstmid_nodone got=%0d want=0", n_fd - bfd);
        end
        rst = 1'b0;
        mark();
        k = 0;
        while (npop == bnp && k < 50) begin step(); k++; end
        total++;
        if (k >= 50 || bus.grant_o !== 2'b01 || n_pop0 - b0 != 1) begin
            bad++;
            $display("FAIL rstmid_regrant grant=%b pop0=%0d want 01/1",
                     bus.grant_o, n_pop0 - b0);
        end
    endtask

    task automatic test_random();
        logic [15:0] w0[12];
        logic [15:0] w1[8];
        int k;
        int m;
        rst_on();
        for (int i = 0; i < 12; i++) begin
            w0[i] = 16'($random);
            q0.push_back(w0[i]);
        end
        for (int i = 0; i < 8; i++) begin
            w1[i] = 16'($random);
            q1.push_back(w1[i]);
        end
        rst_off();
        mark();
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < 4; i++)
                add_word((f % 2 == 0) ? w0[(f/2)*4+i] : w1[(f/2)*4+i]);
        k = 0;
        while (n_fd < bfd + 5 && k < 2000) begin step(); k++; end
        m = 0;
        if (syms.size() - sb != exp_syms.size()) m = -1;
        else for (int i = 0; i < exp_syms.size(); i++)
            if (syms[sb+i] !== exp_syms[i]) m++;
        total++;
        if (k >= 2000 || m != 0) begin
            bad++;
            $display("FAIL random_syms got_n=%0d want_n=%0d mism=%0d",
                     syms.size() - sb, exp_syms.size(), m);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_underflow();
        test_drain_guard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
